seq_shifter: RTL



---
 rtl/seq_shifter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - multi-cycle one-bit-per-clock shifter with valid/ready handshakes
//
// Purpose: shifts an operand one bit position per clock in LSL, LSR, ASR or
// ROR mode and reports the last bit shifted out. A request is accepted with
// in_valid/in_ready; the result is presented with out_valid/out_ready.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   request present
//   in_ready   out  unit can accept a request (IDLE, or DONE with out_ready)
//   a          in   operand [WIDTH]
//   mode       in   00 LSL, 01 LSR, 10 ASR, 11 ROR
//   amt        in   shift amount [AMT_W], 0..WIDTH-1
//   out_valid  out  result present
//   out_ready  in   consumer takes the result
//   y          out  shifted result [WIDTH]
//   carry      out  last bit shifted/rotated out, 0 when amt = 0
//
// Configuration macro: SEQ_SHIFTER_ROTATE_EN
//   defined   - mode 11 rotates right
//   undefined - no rotate logic; mode 11 behaves exactly as LSR

module seq_shifter #(
    parameter int WIDTH = 16,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [1:0]       mode,
    input  logic [AMT_W-1:0] amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             carry
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             carry_q, carry_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;

    logic             accept;
    logic [1:0]       mode_dec;
    logic [WIDTH-1:0] step_y;
    logic             step_c;

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == S_DONE);
    assign y         = y_q;
    assign carry     = carry_q;

    // Mode is resolved once at accept so the shift datapath never sees an
    // encoding it does not implement.
`ifdef SEQ_SHIFTER_ROTATE_EN
    assign mode_dec = mode;
`else
    assign mode_dec = (mode == 2'b11) ? 2'b01 : mode;
`endif

    // One bit position of the held value, plus the bit leaving it.
    always_comb begin
        step_y = y_q;
        step_c = 1'b0;
        case (mode_q)
            2'b00: begin
                step_y = {y_q[WIDTH-2:0], 1'b0};
                step_c = y_q[WIDTH-1];
            end
            2'b10: begin
                step_y = {y_q[WIDTH-1], y_q[WIDTH-1:1]};
                step_c = y_q[0];
            end
`ifdef SEQ_SHIFTER_ROTATE_EN
            2'b11: begin
                step_y = {y_q[0], y_q[WIDTH-1:1]};
                step_c = y_q[0];
            end
`endif
            default: begin
                step_y = {1'b0, y_q[WIDTH-1:1]};
                step_c = y_q[0];
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;

        if (accept) begin
            y_d     = a;
            carry_d = 1'b0;
            cnt_d   = amt;
            mode_d  = mode_dec;
            state_d = (amt == '0) ? S_DONE : S_SHIFT;
        end else begin
            case (state_q)
                S_SHIFT: begin
                    y_d     = step_y;
                    carry_d = step_c;
                    cnt_d   = cnt_q - AMT_W'(1);
                    if (cnt_q == AMT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            y_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

endmodule
